// File: rtl/msq_pkg.sv
// Shared types and helpers for the multi-channel sample sequencer.
// Holds the FSM encoding, the channel-index width and the next-enabled-channel search.
package msq_pkg;

  localparam int MAX_CH    = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_FIN  = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_DONE      = 3'd4
  } msq_state_e;

  typedef struct packed {
    logic                 none;
    logic [MAX_IDX_W-1:0] idx;
  } next_ch_t;

  function automatic int ch_idx_w(input int num_ch);
    int w;
    w = $clog2(num_ch);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

  // Lowest set bit strictly above cur; cur = -1 yields the first set bit.
  function automatic next_ch_t next_ch(input logic [MAX_CH-1:0] mask, input int cur);
    next_ch_t res;
    res.none = 1'b1;
    res.idx  = {MAX_IDX_W{1'b0}};
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > cur)) begin
        res.none = 1'b0;
        res.idx  = MAX_IDX_W'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/msq_prio_sel.sv
// Combinational priority finder: next enabled channel above a start index,
// or the first enabled channel when from_first is set.
module msq_prio_sel
  import msq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [IDX_W-1:0]  cur,
  input  logic              from_first,
  output logic [IDX_W-1:0]  idx,
  output logic              none
);

  next_ch_t res_s;
  int       cur_s;

  // Search the mask from the requested position
  always_comb begin
    if (from_first) begin
      cur_s = -32'sd1;
    end else begin
      cur_s = int'(cur);
    end
    res_s = next_ch(MAX_CH'(mask), cur_s);
    idx   = IDX_W'(res_s.idx);
    none  = res_s.none;
  end

endmodule

// File: rtl/multi_channel_sample_sequencer.sv
// Time-multiplexes one start/idle/fin engine over NUM_CH channels and publishes
// every frame's results together; samples arriving while busy are counted as overruns.
module multi_channel_sample_sequencer
  import msq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int OVR_W  = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         sample_ready,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH*DATA_W-1:0]     ch_in,
  input  logic                         eng_idle,
  input  logic                         eng_fin,
  input  logic [DATA_W-1:0]            eng_result,
  output logic [DATA_W-1:0]            eng_sample,
  output logic                         eng_start,
  output logic [ch_idx_w(NUM_CH)-1:0]  eng_ch,
  output logic [NUM_CH*DATA_W-1:0]     ch_out,
  output logic                         frame_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic [OVR_W-1:0]             overrun_cnt
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  msq_state_e        state_r;
  msq_state_e        state_nxt_s;
  logic [IDX_W-1:0]  cur_r;
  logic [IDX_W-1:0]  cur_nxt_s;
  logic [NUM_CH-1:0] mask_r;

  logic [DATA_W-1:0] in_a_s     [NUM_CH];
  logic [DATA_W-1:0] snap_r     [NUM_CH];
  logic [DATA_W-1:0] shadow_r   [NUM_CH];
  logic [DATA_W-1:0] out_r      [NUM_CH];
  logic [DATA_W-1:0] commit_s   [NUM_CH];

  logic              sel_first_s;
  logic [NUM_CH-1:0] sel_mask_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic              sel_none_s;
  logic              accept_s;
  logic              capture_s;
  logic              drop_s;
  logic [DATA_W-1:0] start_sample_s;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_flat
    assign in_a_s[k]                   = ch_in[k*DATA_W +: DATA_W];
    assign ch_out[k*DATA_W +: DATA_W]  = out_r[k];
  end

  // In IDLE the finder looks at the live enable mask, afterwards at the latched one.
  msq_prio_sel #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_prio_sel (
    .mask       (sel_mask_s),
    .cur        (cur_r),
    .from_first (sel_first_s),
    .idx        (sel_idx_s),
    .none       (sel_none_s)
  );

  // Event decode and next-state logic
  always_comb begin
    sel_first_s = (state_r == ST_IDLE);
    sel_mask_s  = sel_first_s ? ch_enable : mask_r;
    accept_s    = sel_first_s && sample_ready && (ch_enable != {NUM_CH{1'b0}});
    drop_s      = sample_ready && !sel_first_s;
    capture_s   = (state_r == ST_WAIT_FIN) && eng_fin;
    state_nxt_s = state_r;
    cur_nxt_s   = cur_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_START;
          cur_nxt_s   = sel_idx_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt_s = ST_WAIT_FIN;
      end
      ST_WAIT_FIN: begin
        if (!eng_fin) begin
          state_nxt_s = ST_WAIT_FIN;
        end else if (!sel_none_s) begin
          state_nxt_s = ST_WAIT_IDLE;
          cur_nxt_s   = sel_idx_s;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_WAIT_IDLE: begin
        if (eng_idle) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_WAIT_IDLE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cur_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
    // On acceptance the snapshot is not loaded yet, so read the live input.
    if (sel_first_s) begin
      start_sample_s = in_a_s[sel_idx_s];
    end else begin
      start_sample_s = snap_r[cur_nxt_s];
    end
  end

  // Frame commit values; the last result bypasses the shadow it is being written to
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (!mask_r[k]) begin
        commit_s[k] = out_r[k];
      end else if (capture_s && (cur_r == IDX_W'(k))) begin
        commit_s[k] = eng_result;
      end else begin
        commit_s[k] = shadow_r[k];
      end
    end
  end

  // State, snapshot, shadow and committed-output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      cur_r   <= {IDX_W{1'b0}};
      mask_r  <= {NUM_CH{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
        snap_r[k]   <= {DATA_W{1'b0}};
        shadow_r[k] <= {DATA_W{1'b0}};
        out_r[k]    <= {DATA_W{1'b0}};
      end
    end else begin
      state_r <= state_nxt_s;
      cur_r   <= cur_nxt_s;
      if (accept_s) begin
        mask_r <= ch_enable;
        for (int k = 0; k < NUM_CH; k++) begin
          snap_r[k] <= in_a_s[k];
        end
      end
      if (capture_s) begin
        shadow_r[cur_r] <= eng_result;
      end
      if (state_nxt_s == ST_DONE) begin
        for (int k = 0; k < NUM_CH; k++) begin
          out_r[k] <= commit_s[k];
        end
      end
    end
  end

  // Engine-facing and status outputs, registered from the next state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      eng_start   <= 1'b0;
      eng_sample  <= {DATA_W{1'b0}};
      eng_ch      <= {IDX_W{1'b0}};
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= {OVR_W{1'b0}};
    end else begin
      eng_start   <= (state_nxt_s == ST_START);
      frame_valid <= (state_nxt_s == ST_DONE);
      busy        <= (state_nxt_s != ST_IDLE);
      overrun     <= drop_s;
      case (state_nxt_s)
        ST_START: begin
          eng_sample <= start_sample_s;
          eng_ch     <= cur_nxt_s;
        end
        ST_WAIT_FIN, ST_WAIT_IDLE: begin
          eng_sample <= eng_sample;
          eng_ch     <= eng_ch;
        end
        default: begin
          eng_sample <= {DATA_W{1'b0}};
          eng_ch     <= {IDX_W{1'b0}};
        end
      endcase
      if (drop_s && (overrun_cnt != {OVR_W{1'b1}})) begin
        overrun_cnt <= overrun_cnt + {{(OVR_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_sample_sequencer.sv
// Directed bench for the sample sequencer with a behavioural engine (result = sample+100,
// fin three cycles after start); a second instance with OVR_W=2 covers counter saturation.
module tb_multi_channel_sample_sequencer;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         sample_ready = 1'b0;
  logic         sample_ready2 = 1'b0;
  logic [3:0]   ch_enable = 4'h0;
  logic [127:0] ch_in = 128'd0;
  logic         eng_idle = 1'b1;
  logic         eng_fin = 1'b0;
  logic [31:0]  eng_result = 32'd0;

  logic [31:0]  eng_sample, eng_sample2;
  logic         eng_start, eng_start2;
  logic [1:0]   eng_ch, eng_ch2;
  logic [127:0] ch_out, ch_out2;
  logic         frame_valid, frame_valid2, busy, busy2, overrun, overrun2;
  logic [15:0]  overrun_cnt;
  logic [1:0]   overrun_cnt2;

  multi_channel_sample_sequencer #(.NUM_CH(4), .DATA_W(32), .OVR_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .sample_ready(sample_ready), .ch_enable(ch_enable),
    .ch_in(ch_in), .eng_idle(eng_idle), .eng_fin(eng_fin), .eng_result(eng_result),
    .eng_sample(eng_sample), .eng_start(eng_start), .eng_ch(eng_ch), .ch_out(ch_out),
    .frame_valid(frame_valid), .busy(busy), .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  multi_channel_sample_sequencer #(.NUM_CH(4), .DATA_W(32), .OVR_W(2)) dut_sat (
    .CLK(CLK), .RESET(RESET), .sample_ready(sample_ready2), .ch_enable(ch_enable),
    .ch_in(ch_in), .eng_idle(eng_idle), .eng_fin(eng_fin), .eng_result(eng_result),
    .eng_sample(eng_sample2), .eng_start(eng_start2), .eng_ch(eng_ch2), .ch_out(ch_out2),
    .frame_valid(frame_valid2), .busy(busy2), .overrun(overrun2), .overrun_cnt(overrun_cnt2)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Engine model, driven just after each rising edge; it only serves the main instance.
  int          eng_cnt = 0;
  logic [31:0] eng_res = 32'd0;
  logic        hold_req = 1'b0;
  logic        hold_used = 1'b0;
  int          idle_cnt = 0;
  int          idle_rise_cyc = -1;
  always @(posedge CLK) begin
    #1;
    if (RESET) begin
      eng_cnt = 0; eng_fin = 1'b0; eng_idle = 1'b1; idle_cnt = 0;
    end else begin
      if (idle_cnt > 0) begin
        idle_cnt--;
        if (idle_cnt == 0) begin eng_idle = 1'b1; idle_rise_cyc = cyc; end
      end
      if (eng_start) begin
        eng_cnt = 3; eng_res = eng_sample + 32'd100; eng_fin = 1'b0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_fin = 1'b1; eng_result = eng_res;
          if (hold_req && !hold_used) begin hold_used = 1'b1; eng_idle = 1'b0; idle_cnt = 10; end
        end else eng_fin = 1'b0;
      end else eng_fin = 1'b0;
    end
  end

  // Event log of the main instance
  logic [31:0] st_smp[$];
  int          st_ch[$];
  int          st_cyc[$];
  int          fv_cnt = 0;
  int          ov_pulses = 0;
  always @(negedge CLK) begin
    if (!RESET) begin
      if (eng_start) begin st_smp.push_back(eng_sample); st_ch.push_back(int'(eng_ch)); st_cyc.push_back(cyc); end
      if (frame_valid) fv_cnt++;
      if (overrun) ov_pulses++;
    end
  end

  int errors = 0;
  int checks = 0;
  int sr_cyc = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_log();
    st_smp.delete(); st_ch.delete(); st_cyc.delete();
  endtask

  task automatic pulse(input logic [3:0] m, input logic [127:0] d);
    ch_enable = m; ch_in = d; sample_ready = 1'b1; sr_cyc = cyc;
    @(negedge CLK);
    sample_ready = 1'b0;
  endtask

  task automatic wait_fv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frame_valid) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  task automatic wait_start(input int budget, input int want_ch, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (eng_start && (want_ch < 0 || int'(eng_ch) == want_ch)) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(3);
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
    checks++; if (eng_sample !== 32'd0) begin errors++; $display("FAIL reset_eng_sample: got %0h want 0", eng_sample); end
    checks++; if (eng_ch !== 2'd0) begin errors++; $display("FAIL reset_eng_ch: got %0d want 0", eng_ch); end
    checks++; if (ch_out !== 128'd0) begin errors++; $display("FAIL reset_ch_out: got %0h want 0", ch_out); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_overrun_cnt: got %0d want 0", overrun_cnt); end
    RESET = 1'b0;
    tick(2);
  endtask

  task automatic test_full_frame();
    bit ok; int fv0;
    clear_log(); fv0 = fv_cnt;
    pulse(4'hF, {32'd4, 32'd3, 32'd2, 32'd1});
    wait_fv(120, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_frame_timeout: no frame_valid within 120 cycles"); end
    checks++; if (ch_out !== {32'd104, 32'd103, 32'd102, 32'd101}) begin errors++; $display("FAIL full_ch_out: got %0h want 104/103/102/101", ch_out); end
    tick(4);
    checks++; if (st_smp.size() != 4) begin errors++; $display("FAIL full_start_count: got %0d want 4", st_smp.size()); end
    for (int i = 0; i < st_smp.size(); i++) begin
      checks++; if (st_smp[i] !== 32'(i + 1) || st_ch[i] != i) begin errors++; $display("FAIL full_start_%0d: got sample %0d ch %0d want sample %0d ch %0d", i, st_smp[i], st_ch[i], i + 1, i); end
    end
    checks++; if (st_cyc.size() == 0 || st_cyc[0] != sr_cyc + 1) begin errors++; $display("FAIL full_latency: sample_ready cycle %0d, first start not at %0d", sr_cyc, sr_cyc + 1); end
    checks++; if (fv_cnt != fv0 + 1) begin errors++; $display("FAIL full_fv_count: got %0d want %0d", fv_cnt - fv0, 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_partial_mask();
    bit ok;
    clear_log();
    pulse(4'b1010, {32'd40, 32'd30, 32'd20, 32'd10});
    wait_fv(120, ok);
    checks++; if (!ok) begin errors++; $display("FAIL partial_timeout: no frame_valid within 120 cycles"); end
    checks++; if (ch_out !== {32'd140, 32'd103, 32'd120, 32'd101}) begin errors++; $display("FAIL partial_ch_out: got %0h want 140/103/120/101", ch_out); end
    tick(3);
    checks++; if (st_smp.size() != 2) begin errors++; $display("FAIL partial_start_count: got %0d want 2", st_smp.size()); end
    checks++; if (st_smp.size() < 2 || st_smp[0] !== 32'd20 || st_smp[1] !== 32'd40 || st_ch[0] != 1 || st_ch[1] != 3) begin errors++; $display("FAIL partial_order: starts did not go to ch1 (20) then ch3 (40)"); end
  endtask

  task automatic test_mask_zero();
    int fv0, ov0, busy_hi;
    clear_log(); fv0 = fv_cnt; ov0 = ov_pulses; busy_hi = 0;
    pulse(4'h0, {32'd9, 32'd9, 32'd9, 32'd9});
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_hi++;
      @(negedge CLK);
    end
    checks++; if (st_smp.size() != 0) begin errors++; $display("FAIL zero_starts: got %0d want 0", st_smp.size()); end
    checks++; if (fv_cnt != fv0) begin errors++; $display("FAIL zero_frame_valid: got %0d want 0", fv_cnt - fv0); end
    checks++; if (busy_hi != 0) begin errors++; $display("FAIL zero_busy: busy high %0d cycles want 0", busy_hi); end
    checks++; if (ov_pulses != ov0 || overrun_cnt !== 16'd0) begin errors++; $display("FAIL zero_overrun: pulses %0d cnt %0d want 0 0", ov_pulses - ov0, overrun_cnt); end
  endtask

  task automatic test_overrun();
    bit ok; int ov0;
    clear_log(); ov0 = ov_pulses;
    pulse(4'hF, {32'd8, 32'd7, 32'd6, 32'd5});
    wait_start(10, 0, ok);
    @(negedge CLK);
    pulse(4'h1, {32'd99, 32'd99, 32'd99, 32'd99});
    wait_fv(120, ok);
    checks++; if (!ok) begin errors++; $display("FAIL overrun_timeout: no frame_valid within 120 cycles"); end
    pulse(4'hF, {32'd77, 32'd77, 32'd77, 32'd77});
    tick(5);
    checks++; if (ov_pulses != ov0 + 2) begin errors++; $display("FAIL overrun_pulses: got %0d want 2", ov_pulses - ov0); end
    checks++; if (overrun_cnt !== 16'd2) begin errors++; $display("FAIL overrun_cnt: got %0d want 2", overrun_cnt); end
    checks++; if (ch_out !== {32'd108, 32'd107, 32'd106, 32'd105}) begin errors++; $display("FAIL overrun_ch_out: got %0h want 108/107/106/105", ch_out); end
    checks++; if (st_smp.size() != 4 || st_smp[0] !== 32'd5 || st_smp[3] !== 32'd8) begin errors++; $display("FAIL overrun_starts: %0d starts, frame was disturbed", st_smp.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overrun_busy: got %b want 0", busy); end
  endtask

  task automatic test_idle_hold();
    bit ok; int bad, s2;
    clear_log(); bad = 0; s2 = -1;
    hold_req = 1'b1;
    pulse(4'b0011, {32'd0, 32'd0, 32'd34, 32'd17});
    wait_start(10, 0, ok);
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (!eng_idle && (eng_start || !busy)) bad++;
      if (eng_start) begin s2 = cyc; break; end
    end
    hold_req = 1'b0;
    checks++; if (s2 < 0) begin errors++; $display("FAIL hold_second_start: no second start within 60 cycles"); end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_wait_idle: %0d cycles with start or !busy while engine not idle", bad); end
    checks++; if (s2 != idle_rise_cyc + 1) begin errors++; $display("FAIL hold_restart_cycle: got %0d want %0d", s2, idle_rise_cyc + 1); end
    wait_fv(60, ok);
    checks++; if (!ok || ch_out !== {32'd108, 32'd107, 32'd134, 32'd117}) begin errors++; $display("FAIL hold_ch_out: got %0h want 108/107/134/117", ch_out); end
    tick(3);
  endtask

  task automatic test_saturate();
    ch_enable = 4'hF;
    sample_ready2 = 1'b1;
    @(negedge CLK);
    sample_ready2 = 1'b0;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      sample_ready2 = 1'b1;
      @(negedge CLK);
      sample_ready2 = 1'b0;
      @(negedge CLK);
      if (i == 1) begin
        checks++; if (overrun_cnt2 !== 2'd2) begin errors++; $display("FAIL sat_cnt_two: got %0d want 2", overrun_cnt2); end
      end
    end
    checks++; if (overrun_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt_five: got %0d want 3", overrun_cnt2); end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL sat_busy: got %b want 1", busy2); end
  endtask

  task automatic test_reset_midframe();
    bit ok; int fv0;
    clear_log();
    pulse(4'hF, {32'd4, 32'd3, 32'd2, 32'd1});
    wait_start(80, 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_reach_ch2: channel 2 never started"); end
    @(negedge CLK);
    RESET = 1'b1; fv0 = fv_cnt;
    @(negedge CLK);
    checks++; if (ch_out !== 128'd0 || frame_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_outputs: ch_out %0h fv %b busy %b want 0", ch_out, frame_valid, busy); end
    checks++; if (eng_start !== 1'b0 || eng_sample !== 32'd0 || eng_ch !== 2'd0) begin errors++; $display("FAIL midreset_engine: start %b sample %0d ch %0d want 0", eng_start, eng_sample, eng_ch); end
    checks++; if (overrun_cnt !== 16'd0 || overrun_cnt2 !== 2'd0 || busy2 !== 1'b0) begin errors++; $display("FAIL midreset_counters: cnt %0d cnt2 %0d busy2 %b want 0", overrun_cnt, overrun_cnt2, busy2); end
    RESET = 1'b0;
    tick(2);
    clear_log();
    pulse(4'b1100, {32'd4, 32'd3, 32'd2, 32'd1});
    wait_fv(120, ok);
    checks++; if (!ok || ch_out !== {32'd104, 32'd103, 32'd0, 32'd0}) begin errors++; $display("FAIL midreset_restart_out: got %0h want 104/103/0/0", ch_out); end
    tick(3);
    checks++; if (st_smp.size() != 2 || st_ch[0] != 2 || st_smp[0] !== 32'd3) begin errors++; $display("FAIL midreset_restart_order: %0d starts, first not ch2 sample 3", st_smp.size()); end
    checks++; if (fv_cnt != fv0 + 1) begin errors++; $display("FAIL midreset_fv_count: got %0d want 1", fv_cnt - fv0); end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_full_frame();
    test_partial_mask();
    test_mask_zero();
    test_overrun();
    test_idle_hold();
    test_saturate();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
